// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: drains the receiver FIFO and tracks the last make code.
// Define PS2_KEY_EXT_EN to honour the E0 extended-key prefix; otherwise E0 is discarded.
module ps2_key_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       ready,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_valid,
    output logic       key_down,
    output logic       key_ext,
    output logic [7:0] press_cnt
);

`ifdef PS2_KEY_EXT_EN
    localparam logic ExtEn = 1'b1;
`else
    localparam logic ExtEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StPop, StGap} state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_key_code, w_key_code_d;
    logic       r_key_valid, w_key_valid_d;
    logic       r_key_down, w_key_down_d;
    logic       r_key_ext, w_key_ext_d;
    logic [7:0] r_press_cnt, w_press_cnt_d;
    logic       r_brk_pend, w_brk_pend_d;
    logic       r_ext_pend, w_ext_pend_d;
    logic       w_brk_eff, w_ext_eff;

    always_comb begin
        w_state_d     = r_state;
        w_key_code_d  = r_key_code;
        w_key_valid_d = 1'b0;
        w_key_down_d  = r_key_down;
        w_key_ext_d   = r_key_ext;
        w_press_cnt_d = r_press_cnt;
        w_brk_pend_d  = r_brk_pend;
        w_ext_pend_d  = r_ext_pend;
        w_brk_eff     = r_brk_pend;
        w_ext_eff     = r_ext_pend;
        case (r_state)
            StIdle: begin
                // Overflow drops any half-received prefix before this byte is decoded.
                if (overflow) begin
                    w_brk_eff    = 1'b0;
                    w_ext_eff    = 1'b0;
                    w_brk_pend_d = 1'b0;
                    w_ext_pend_d = 1'b0;
                end
                if (ready) begin
                    w_state_d = StPop;
                    if (data == 8'hF0) begin
                        w_brk_pend_d = 1'b1;
                    end else if (data == 8'hE0) begin
                        if (ExtEn) w_ext_pend_d = 1'b1;
                    end else if (w_brk_eff) begin
                        if (data == r_key_code) w_key_down_d = 1'b0;
                        w_brk_pend_d = 1'b0;
                        w_ext_pend_d = 1'b0;
                    end else begin
                        // Same key still held is typematic repeat, not a new press.
                        if (!(data == r_key_code && r_key_down)) begin
                            w_key_code_d  = data;
                            w_key_down_d  = 1'b1;
                            w_key_ext_d   = w_ext_eff;
                            w_key_valid_d = 1'b1;
                            w_press_cnt_d = r_press_cnt + 8'd1;
                        end
                        w_ext_pend_d = 1'b0;
                    end
                end
            end
            StPop:   w_state_d = StGap;
            StGap:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_key_code  <= 8'h00;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
            r_key_ext   <= 1'b0;
            r_press_cnt <= 8'h00;
            r_brk_pend  <= 1'b0;
            r_ext_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_key_code  <= w_key_code_d;
            r_key_valid <= w_key_valid_d;
            r_key_down  <= w_key_down_d;
            r_key_ext   <= w_key_ext_d;
            r_press_cnt <= w_press_cnt_d;
            r_brk_pend  <= w_brk_pend_d;
            r_ext_pend  <= w_ext_pend_d;
        end
    end

    // Decoded from the state register so an async reset in POP withdraws the pop at once.
    assign nextdata_n = (r_state != StPop);
    assign key_code   = r_key_code;
    assign key_valid  = r_key_valid;
    assign key_down   = r_key_down;
    assign key_ext    = ExtEn & r_key_ext;
    assign press_cnt  = r_press_cnt;

    always_comb begin
        key_ascii = 8'h00;
        case (r_key_code)
            8'h1C: key_ascii = 8'h61;
            8'h32: key_ascii = 8'h62;
            8'h21: key_ascii = 8'h63;
            8'h23: key_ascii = 8'h64;
            8'h24: key_ascii = 8'h65;
            8'h2B: key_ascii = 8'h66;
            8'h34: key_ascii = 8'h67;
            8'h33: key_ascii = 8'h68;
            8'h43: key_ascii = 8'h69;
            8'h3B: key_ascii = 8'h6A;
            8'h42: key_ascii = 8'h6B;
            8'h4B: key_ascii = 8'h6C;
            8'h3A: key_ascii = 8'h6D;
            8'h31: key_ascii = 8'h6E;
            8'h44: key_ascii = 8'h6F;
            8'h4D: key_ascii = 8'h70;
            8'h15: key_ascii = 8'h71;
            8'h2D: key_ascii = 8'h72;
            8'h1B: key_ascii = 8'h73;
            8'h2C: key_ascii = 8'h74;
            8'h3C: key_ascii = 8'h75;
            8'h2A: key_ascii = 8'h76;
            8'h1D: key_ascii = 8'h77;
            8'h22: key_ascii = 8'h78;
            8'h35: key_ascii = 8'h79;
            8'h1A: key_ascii = 8'h7A;
            8'h16: key_ascii = 8'h31;
            8'h1E: key_ascii = 8'h32;
            8'h26: key_ascii = 8'h33;
            8'h25: key_ascii = 8'h34;
            8'h2E: key_ascii = 8'h35;
            8'h36: key_ascii = 8'h36;
            8'h3D: key_ascii = 8'h37;
            8'h3E: key_ascii = 8'h38;
            8'h46: key_ascii = 8'h39;
            8'h45: key_ascii = 8'h30;
            8'h29: key_ascii = 8'h20;
            default: key_ascii = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: FIFO model feeding the DUT, checked against a
// byte-level reference model of the make/break/prefix rules.
module tb_ps2_key_decoder;

`ifdef PS2_KEY_EXT_EN
    localparam logic ExtEn = 1'b1;
`else
    localparam logic ExtEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic       overflow = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code, key_ascii, press_cnt;
    logic       key_valid, key_down, key_ext;

    ps2_key_decoder u_dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ascii  (key_ascii),
        .key_valid  (key_valid),
        .key_down   (key_down),
        .key_ext    (key_ext),
        .press_cnt  (press_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    int pops = 0;
    int vcount = 0;

    always @(posedge clk) begin
        if (!nextdata_n && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
        end
    end

    always @(negedge clk) begin
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'h00;
        if (key_valid) vcount++;
    end

    // Reference model state
    logic [7:0] m_code, m_cnt;
    logic       m_down, m_kext, m_brk, m_ext;
    int         m_valid, m_pops, vbase, pbase;
    int         n_checks = 0;
    int         n_fail = 0;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                8'h45};
    logic [7:0] pool [8] = '{8'h1C, 8'h32, 8'h15, 8'h23, 8'h16, 8'h45, 8'h29, 8'h75};

    function automatic logic [7:0] ascii_of(input logic [7:0] c);
        logic [7:0] a;
        a = 8'h00;
        for (int i = 0; i < 26; i++) if (letters[i] == c) a = 8'(8'h61 + i);
        for (int i = 0; i < 10; i++) if (digits[i] == c) a = 8'(8'h30 + ((i + 1) % 10));
        if (c == 8'h29) a = 8'h20;
        return a;
    endfunction

    task automatic model_reset();
        m_code = 8'h00; m_cnt = 8'h00; m_down = 1'b0; m_kext = 1'b0;
        m_brk = 1'b0; m_ext = 1'b0; m_valid = 0; m_pops = 0;
        vbase = vcount; pbase = pops;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            if (ExtEn) m_ext = 1'b1;
        end else if (m_brk) begin
            if (b == m_code) m_down = 1'b0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            if (!(b == m_code && m_down)) begin
                m_code = b; m_down = 1'b1; m_kext = m_ext;
                m_cnt = m_cnt + 8'd1; m_valid++;
            end
            m_ext = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
        m_pops++;
    endtask

    task automatic drain();
        int lim;
        int i;
        lim = 3 * fifo.size() + 30;
        i = 0;
        while (fifo.size() != 0 && i < lim) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (fifo.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes left, required 0", fifo.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        overflow = 1'b0;
        fifo.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({key_code, key_ascii, press_cnt} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_bytes: code=%h ascii=%h cnt=%h required 00", key_code, key_ascii,
                     press_cnt);
        end
        n_checks++;
        if ({key_valid, key_down, key_ext, nextdata_n} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_bits: valid/down/ext/nextdata_n=%b required 0001",
                     {key_valid, key_down, key_ext, nextdata_n});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_make_break();
        do_reset();
        push(8'h15);
        drain();
        n_checks++;
        if (key_down !== 1'b1 || key_code !== 8'h15 || key_ascii !== 8'h71) begin
            n_fail++;
            $display("FAIL make_q: down=%b code=%h ascii=%h required 1 15 71", key_down, key_code,
                     key_ascii);
        end
        push(8'hF0);
        push(8'h15);
        drain();
        n_checks++;
        if (key_down !== 1'b0 || press_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL break_q: down=%b cnt=%h required 0 01", key_down, press_cnt);
        end
        n_checks++;
        if (vcount - vbase !== 1 || pops - pbase !== 3) begin
            n_fail++;
            $display("FAIL pulses_q: valid=%0d pops=%0d required 1 3", vcount - vbase,
                     pops - pbase);
        end
    endtask

    task automatic test_typematic();
        do_reset();
        push(8'h23); push(8'h23); push(8'h23); push(8'hF0); push(8'h23);
        drain();
        n_checks++;
        if (vcount - vbase !== 1 || press_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL typematic_cnt: valid=%0d cnt=%h required 1 01", vcount - vbase,
                     press_cnt);
        end
        n_checks++;
        if (key_ascii !== 8'h64 || key_down !== 1'b0 || pops - pbase !== 5) begin
            n_fail++;
            $display("FAIL typematic_end: ascii=%h down=%b pops=%0d required 64 0 5", key_ascii,
                     key_down, pops - pbase);
        end
    endtask

    task automatic test_ext();
        do_reset();
        push(8'hE0); push(8'h75); push(8'hF0); push(8'hE0); push(8'h75);
        drain();
        n_checks++;
        if (key_code !== 8'h75 || key_ext !== ExtEn || key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_seq: code=%h ext=%b down=%b required 75 %b 0", key_code, key_ext,
                     key_down, ExtEn);
        end
        n_checks++;
        if (press_cnt !== 8'd1 || pops - pbase !== 5) begin
            n_fail++;
            $display("FAIL ext_cnt: cnt=%h pops=%0d required 01 5", press_cnt, pops - pbase);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] k;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            k = (i % 2 == 0) ? 8'h1C : 8'h32;
            push(k); push(8'hF0); push(k);
        end
        drain();
        n_checks++;
        if (press_cnt !== 8'h00 || m_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_cnt: cnt=%h required 00", press_cnt);
        end
        n_checks++;
        if (vcount - vbase !== 256 || pops - pbase !== 768) begin
            n_fail++;
            $display("FAIL wrap_pulses: valid=%0d pops=%0d required 256 768", vcount - vbase,
                     pops - pbase);
        end
    endtask

    task automatic test_reset_in_pop();
        int i;
        do_reset();
        fifo.push_back(8'h15);
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (nextdata_n !== 1'b0 && i < 10);
        n_checks++;
        if (nextdata_n !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_seen: nextdata_n=%b required 0", nextdata_n);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({key_code, key_ascii, press_cnt} !== 24'h0 ||
            {key_valid, key_down, key_ext, nextdata_n} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_in_pop: code=%h cnt=%h v/d/e/n=%b required 00 00 0001", key_code,
                     press_cnt, {key_valid, key_down, key_ext, nextdata_n});
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (fifo.size() !== 1) begin
            n_fail++;
            $display("FAIL rst_kept_byte: fifo=%0d required 1", fifo.size());
        end
        model_reset();
        model_byte(8'h15);
        m_pops = 1;
        drain();
        n_checks++;
        if (press_cnt !== 8'd1 || key_code !== 8'h15 || pops - pbase !== 1) begin
            n_fail++;
            $display("FAIL rst_redecode: cnt=%h code=%h pops=%0d required 01 15 1", press_cnt,
                     key_code, pops - pbase);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push(8'hF0);
        drain();
        @(negedge clk);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        push(8'h1C);
        drain();
        n_checks++;
        if (press_cnt !== 8'd1 || key_code !== 8'h1C || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_make: cnt=%h code=%h down=%b required 01 1c 1", press_cnt,
                     key_code, key_down);
        end
    endtask

    task automatic test_random();
        int    got [8];
        int    exp [8];
        string nm  [8] = '{"key_code", "key_ascii", "key_down", "key_ext", "press_cnt",
                           "valid_pulses", "pops", "nextdata_n"};
        int    r;
        do_reset();
        for (int round = 0; round < 12; round++) begin
            for (int n = 0; n < int'($urandom_range(1, 25)); n++) begin
                r = int'($urandom_range(0, 99));
                if (r < 25)      push(8'hF0);
                else if (r < 35) push(8'hE0);
                else if (r < 75) push(pool[$urandom_range(0, 7)]);
                else             push(8'($urandom));
            end
            drain();
            if ($urandom_range(0, 3) == 0) begin
                overflow = 1'b1;
                @(negedge clk);
                overflow = 1'b0;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
            repeat ($urandom_range(0, 8)) @(negedge clk);
            got = '{int'(key_code), int'(key_ascii), int'(key_down), int'(key_ext),
                    int'(press_cnt), vcount - vbase, pops - pbase, int'(nextdata_n)};
            exp = '{int'(m_code), int'(ascii_of(m_code)), int'(m_down), int'(ExtEn & m_kext),
                    int'(m_cnt), m_valid, m_pops, 1};
            for (int f = 0; f < 8; f++) begin
                n_checks++;
                if (got[f] !== exp[f]) begin
                    n_fail++;
                    $display("FAIL rand_%s round %0d: got %0h required %0h", nm[f], round,
                             got[f], exp[f]);
                end
            end
        end
    endtask

    task automatic test_idle_hold();
        int p0;
        int v0;
        p0 = pops;
        v0 = vcount;
        repeat (20) @(negedge clk);
        n_checks++;
        if (pops !== p0 || vcount !== v0 || nextdata_n !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hold_pulses: pops+%0d valid+%0d nextdata_n=%b required 0 0 1",
                     pops - p0, vcount - v0, nextdata_n);
        end
        n_checks++;
        if (key_code !== m_code || key_down !== m_down || press_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL idle_hold_state: code=%h down=%b cnt=%h required %h %b %h", key_code,
                     key_down, press_cnt, m_code, m_down, m_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_ext();
        test_wrap();
        test_reset_in_pop();
        test_overflow();
        test_random();
        test_idle_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
